// File: rtl/fft_stage_seq.sv
// Beat sequencer for one radix-2 FFT stage over a 512-point frame.
// Incoming beats alternate between an A span, which is stored in the shift
// register, and a B span, which is paired with the stored A beats in the
// butterfly. Each butterfly result is tagged with its group after BF_LAT cycles.
//
// state | meaning
// IDLE  | waiting for an in_sof beat; a beat without in_sof is dropped
// A_PH  | loading A-span beats into the shift register
// B_PH  | B-span beats feed the butterfly together with the stored A beats
module fft_stage_seq #(
   parameter int BEATS  = 32,
   parameter int SPAN   = 2,
   parameter int BF_LAT = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cfg_en,
   input  logic        in_valid,
   input  logic        in_sof,
   output logic        sr_shift,
   output logic        bf_en,
   output logic [3:0]  tw_addr,
   output logic        ob_valid,
   output logic [2:0]  ob_grp,
   output logic        frame_done,
   output logic        busy,
   output logic        sof_err,
   output logic        drop_err,
   output logic [15:0] frame_cnt
);

   localparam int BW  = $clog2(BEATS);
   localparam int SCW = (SPAN > 1) ? $clog2(SPAN) : 1;
   // A group is one A span followed by one B span.
   localparam int GSH = $clog2(2 * SPAN);

   typedef enum logic [1:0] {IDLE, A_PH, B_PH} state_t;

   state_t          state, state_nx;
   logic [BW-1:0]   beat, beat_nx;
   logic [SCW-1:0]  sc, sc_nx;
   logic            last_sc, last_beat;
   logic [BW-1:0]   beat_grp;
   logic [2:0]      group;
   logic [7:0]      tw_full;
   logic            done_nx, sof_err_nx, drop_nx;
   logic [BF_LAT-1:0] dl_v;
   logic [2:0]      dl_g [BF_LAT];

   assign last_sc   = (sc == SCW'(SPAN - 1));
   assign last_beat = (beat == BW'(BEATS - 1));
   assign beat_grp  = beat >> GSH;
   assign group     = beat_grp[2:0];
   assign tw_full   = 8'(group) * 8'(SPAN) + 8'(sc);
   assign busy      = (state != IDLE);
   assign ob_valid  = dl_v[BF_LAT-1];
   assign ob_grp    = dl_g[BF_LAT-1];

   // State, beat and span counter registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         beat  <= '0;
         sc    <= '0;
      end else begin
         state <= state_nx;
         beat  <= beat_nx;
         sc    <= sc_nx;
      end
   end

   // Next-state logic plus the per-beat strobes, which are combinational.
   always_comb begin
      state_nx   = state;
      beat_nx    = beat;
      sc_nx      = sc;
      sr_shift   = 1'b0;
      bf_en      = 1'b0;
      tw_addr    = 4'd0;
      done_nx    = 1'b0;
      sof_err_nx = 1'b0;
      drop_nx    = 1'b0;
      if (!cfg_en) begin
         state_nx = IDLE;
         beat_nx  = '0;
         sc_nx    = '0;
      end else if (in_valid) begin
         if (in_sof) begin
            // An in_sof beat always (re)starts the frame as beat 0 of an A span.
            sr_shift   = 1'b1;
            sof_err_nx = (state != IDLE);
            beat_nx    = BW'(1);
            if (SPAN > 1) begin
               state_nx = A_PH;
               sc_nx    = SCW'(1);
            end else begin
               state_nx = B_PH;
               sc_nx    = '0;
            end
         end else begin
            case (state)
               IDLE: drop_nx = 1'b1;
               A_PH: begin
                  sr_shift = 1'b1;
                  beat_nx  = beat + BW'(1);
                  if (last_sc) begin
                     state_nx = B_PH;
                     sc_nx    = '0;
                  end else begin
                     sc_nx = sc + SCW'(1);
                  end
               end
               B_PH: begin
                  bf_en   = 1'b1;
                  tw_addr = tw_full[3:0];
                  beat_nx = beat + BW'(1);
                  if (last_beat) begin
                     state_nx = IDLE;
                     beat_nx  = '0;
                     sc_nx    = '0;
                     done_nx  = 1'b1;
                  end else if (last_sc) begin
                     state_nx = A_PH;
                     sc_nx    = '0;
                  end else begin
                     sc_nx = sc + SCW'(1);
                  end
               end
               default: state_nx = IDLE;
            endcase
         end
      end
   end

   // Registered status pulses and the completed-frame counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         frame_done <= 1'b0;
         sof_err    <= 1'b0;
         drop_err   <= 1'b0;
         frame_cnt  <= 16'd0;
      end else begin
         frame_done <= done_nx;
         sof_err    <= sof_err_nx;
         drop_err   <= drop_nx;
         if (done_nx) frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // Butterfly result delay line; keeps draining even when cfg_en drops.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dl_v <= '0;
         for (int i = 0; i < BF_LAT; i++) dl_g[i] <= 3'd0;
      end else begin
         dl_v[0] <= bf_en;
         dl_g[0] <= group;
         for (int i = 1; i < BF_LAT; i++) begin
            dl_v[i] <= dl_v[i-1];
            dl_g[i] <= dl_g[i-1];
         end
      end
   end

endmodule
